// File: rtl/csp_pkg.sv
// rtl/csp_pkg.sv - shared constants and FSM encoding for the CSP flit channel
`timescale 1ns/1ps
package csp_pkg;

    localparam int FLIT_W          = 11;
    localparam int CSP_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        REQ_HI = 2'd2,
        REQ_LO = 2'd3
    } csp_state_e;

endpackage

// File: rtl/csp_sync2.sv
// rtl/csp_sync2.sv - 2-flop synchronizer with async active-low clear to 0
`timescale 1ns/1ps
module csp_sync2
    import csp_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [CSP_SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[CSP_SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[CSP_SYNC_STAGES-1];

endmodule

// File: rtl/csp_flit_tx.sv
// rtl/csp_flit_tx.sv - clocked producer of a 4-phase bundled-data CSP flit channel
`timescale 1ns/1ps
module csp_flit_tx
    import csp_pkg::*;
#(
    parameter int WIDTH = FLIT_W,
    parameter int DEPTH = 4,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_req,
    input  logic             out_ack,
    output logic             busy,
    output logic [CNTW-1:0]  sent_cnt,
    output logic             proto_err
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [1:0] SETTLE = 2'(CSP_SYNC_STAGES);

    csp_state_e       state_q, state_d;
    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] data_q, data_d;
    logic             req_q, req_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [1:0]       settle_q, settle_d;
    logic             ack_s, ack_prev_q;
    logic             empty, full, push, pop;

    csp_sync2 u_ack_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d_i   (out_ack),
        .q_o   (ack_s)
    );

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = in_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    // The synchronizer is cleared by reset, so ack_s only reflects the real
    // peer once the pipeline has refilled; RESYNC waits for that first.
    always_comb begin
        settle_d = settle_q;
        if (state_q == RESYNC && settle_q != SETTLE) begin
            settle_d = settle_q + 2'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            RESYNC: begin
                if (settle_q == SETTLE && !ack_s) state_d = IDLE;
            end
            IDLE: begin
                if (!empty) begin
                    data_d  = mem_q[rptr_q[AW-1:0]];
                    req_d   = 1'b1;
                    pop     = 1'b1;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    cnt_d   = cnt_q + CNTW'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = RESYNC;
        endcase
    end

    // Edges seen during RESYNC belong to a handshake interrupted by reset.
    always_comb begin
        err_d = err_q;
        if (state_q != RESYNC) begin
            if ((ack_s && !ack_prev_q && !req_q) || (!ack_s && ack_prev_q && req_q)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESYNC;
            data_q     <= '0;
            req_q      <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            settle_q   <= 2'd0;
            ack_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            settle_q   <= settle_d;
            ack_prev_q <= ack_s;
        end
    end

    assign in_ready  = !full;
    assign out_data  = data_q;
    assign out_req   = req_q;
    assign busy      = (state_q != IDLE) || !empty;
    assign sent_cnt  = cnt_q;
    assign proto_err = err_q;

endmodule
